// File: rtl/button_event_pkg.sv
// Shared types, default timing constants and a parameter helper for the
// button_event block and its timers.
package button_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHORT,
        LONG
    } btnState_t;

    localparam int DEFAULT_LONG_PRESS_CYCLES = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES     = 10_000_000;
    localparam int DEFAULT_COUNT_WIDTH       = 8;

    function automatic bit checkPositive(input int value, input int min_value);
        return value >= min_value;
    endfunction

endpackage

// File: rtl/event_timer.sv
// Free-running cycle timer with synchronous clear and enable; flags the last
// count of each MAX-cycle period and wraps back to zero on its own.
module event_timer #(
    parameter int MAX = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

    logic [W-1:0] count;

    assign tc = (count == W'(MAX - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into registered press/release/long-press/
// repeat events and keeps a wrapping press counter.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES,
    parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   debounced,
    input  logic                   repeatEn,
    input  logic                   clrCount,
    output logic                   pressPulse,
    output logic                   releasePulse,
    output logic                   longPress,
    output logic                   repeatPulse,
    output logic [COUNT_WIDTH-1:0] pressCount
);

    if (!checkPositive(LONG_PRESS_CYCLES, 2) || !checkPositive(REPEAT_CYCLES, 2)) begin : g_param_check
        $error("button_event: LONG_PRESS_CYCLES and REPEAT_CYCLES must both be >= 2");
    end

    btnState_t state, state_next;

    logic long_tc;
    logic repeat_tc;
    logic press_next;
    logic release_next;
    logic long_next;
    logic repeat_next;
    logic [COUNT_WIDTH-1:0] count_next;

    // The long timer only runs in SHORT, so it is always zero on the press edge.
    event_timer #(.MAX(LONG_PRESS_CYCLES)) u_long_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state != SHORT),
        .en    (state == SHORT),
        .tc    (long_tc)
    );

    event_timer #(.MAX(REPEAT_CYCLES)) u_repeat_timer (
        .clk   (clk),
        .reset (reset),
        .clr   ((state != LONG) || !repeatEn),
        .en    ((state == LONG) && repeatEn),
        .tc    (repeat_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;

        case (state)
            IDLE: begin
                if (debounced) begin
                    state_next = SHORT;
                    press_next = 1'b1;
                end
            end
            SHORT: begin
                if (!debounced) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else if (long_tc) begin
                    state_next = LONG;
                end
            end
            LONG: begin
                if (!debounced) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else if (repeatEn && repeat_tc) begin
                    repeat_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        long_next = (state_next == LONG);

        if (clrCount) begin
            count_next = press_next ? COUNT_WIDTH'(1) : '0;
        end else if (press_next) begin
            count_next = pressCount + COUNT_WIDTH'(1);
        end else begin
            count_next = pressCount;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            longPress    <= 1'b0;
            repeatPulse  <= 1'b0;
            pressCount   <= '0;
        end else begin
            state        <= state_next;
            pressPulse   <= press_next;
            releasePulse <= release_next;
            longPress    <= long_next;
            repeatPulse  <= repeat_next;
            pressCount   <= count_next;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: an elapsed-time event model checked every cycle,
// plus directed scenarios with literal timing and counter expectations.
module tb_button_event;

    localparam int L  = 10;
    localparam int R  = 4;
    localparam int CW = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic debounced = 1'b0;
    logic repeat_en = 1'b0;
    logic clr_count = 1'b0;
    logic press_pulse, release_pulse, long_press, repeat_pulse;
    logic [CW-1:0] press_count;

    always #5 clk = ~clk;

    button_event #(
        .LONG_PRESS_CYCLES (L),
        .REPEAT_CYCLES     (R),
        .COUNT_WIDTH       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .debounced    (debounced),
        .repeatEn     (repeat_en),
        .clrCount     (clr_count),
        .pressPulse   (press_pulse),
        .releasePulse (release_pulse),
        .longPress    (long_press),
        .repeatPulse  (repeat_pulse),
        .pressCount   (press_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] pack(input logic p, input logic r, input logic l,
                                         input logic rp, input logic [CW-1:0] c);
        return {25'd0, p, r, l, rp, c};
    endfunction

    // Behavioural model: outputs derived from time elapsed since the press
    // and since the last repeat anchor, rather than from explicit timers.
    int   cyc = 0;
    bit   m_pressed, m_press, m_rel, m_long, m_rep;
    int   m_t0, m_anchor, m_cnt;
    logic [31:0] m_cnt_bits;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pressed = 0; m_press = 0; m_rel = 0; m_long = 0; m_rep = 0; m_cnt = 0;
        end else begin
            cyc++;
            m_press = 0; m_rel = 0; m_rep = 0;
            if (!m_pressed) begin
                if (debounced) begin
                    m_pressed = 1; m_press = 1; m_t0 = cyc;
                end
            end else if (!debounced) begin
                m_pressed = 0; m_rel = 1; m_long = 0;
            end else if (!m_long) begin
                if (cyc - m_t0 == L) begin
                    m_long = 1; m_anchor = cyc;
                end
            end else if (!repeat_en) begin
                m_anchor = cyc;
            end else if (cyc - m_anchor == R) begin
                m_rep = 1; m_anchor = cyc;
            end
            if (clr_count) m_cnt = m_press ? 1 : 0;
            else if (m_press) m_cnt = (m_cnt + 1) % (1 << CW);
        end
    end

    // Per-cycle comparison plus event time-stamps for the directed checks.
    int n_press = 0, n_rel = 0, n_long_rise = 0;
    int t_press, t_rel, t_long, t_long_fall;
    int rep_q[$];
    logic long_prev = 1'b0;

    always @(negedge clk) begin
        m_cnt_bits = m_cnt;
        check("cycle", pack(press_pulse, release_pulse, long_press, repeat_pulse, press_count),
              pack(m_press, m_rel, m_long, m_rep, m_cnt_bits[CW-1:0]));
        if (press_pulse) begin n_press++; t_press = cyc; end
        if (release_pulse) begin n_rel++; t_rel = cyc; end
        if (long_press && !long_prev) begin n_long_rise++; t_long = cyc; end
        if (!long_press && long_prev && reset) t_long_fall = cyc;
        if (repeat_pulse) rep_q.push_back(cyc - t_press);
        long_prev = long_press;
    end

    task automatic hold(input logic v, input int k);
        repeat (k) begin
            @(negedge clk);
            debounced = v;
        end
    endtask

    int p0, r0, l0;
    int exp_rep[5] = '{14, 18, 22, 26, 30};
    int exp_cnt[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", pack(press_pulse, release_pulse, long_press, repeat_pulse, press_count), 32'd0);
        reset = 1'b1;

        // 1: short press of 5 cycles
        hold(0, 2);
        p0 = n_press; r0 = n_rel; l0 = n_long_rise;
        hold(1, 5); hold(0, 3);
        check("t1_press_pulses", n_press - p0, 1);
        check("t1_release_pulses", n_rel - r0, 1);
        check("t1_release_at", t_rel - t_press, 5);
        check("t1_no_long", n_long_rise - l0, 0);
        check("t1_count", press_count, 1);

        // 2: long hold with repeat enabled
        repeat_en = 1'b1;
        rep_q.delete();
        hold(1, 31); hold(0, 3);
        check("t2_long_rise", t_long - t_press, L);
        check("t2_rep_count", rep_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2_rep%0d", i), (i < rep_q.size()) ? rep_q[i] : -1, exp_rep[i]);
        check("t2_release_at", t_rel - t_press, 31);
        check("t2_long_fall", t_long_fall, t_rel);

        // 3: long hold with repeat disabled, enabled after +20
        repeat_en = 1'b0;
        rep_q.delete();
        hold(1, 22);
        check("t3_no_rep", rep_q.size(), 0);
        repeat_en = 1'b1;
        hold(1, 5); hold(0, 3);
        check("t3_long_rise", t_long - t_press, L);
        check("t3_rep_count", rep_q.size(), 1);
        check("t3_rep_at", (rep_q.size() > 0) ? rep_q[0] : -1, 24);

        // 4: release exactly when the long timer reaches its last count
        l0 = n_long_rise; r0 = n_rel;
        hold(1, 10); hold(0, 3);
        check("t4_release", n_rel - r0, 1);
        check("t4_release_at", t_rel - t_press, 10);
        check("t4_no_long", n_long_rise - l0, 0);

        // 5: counter clear, wrap, clear together with a press
        check("t5_before_clr", press_count, 4);
        @(negedge clk); clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        check("t5_cleared", press_count, 0);
        for (int i = 0; i < 9; i++) begin
            hold(1, 2); hold(0, 2);
            check($sformatf("t5_count%0d", i), press_count, exp_cnt[i]);
        end
        @(negedge clk); debounced = 1'b1; clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        check("t5_clr_with_press", press_count, 1);
        hold(0, 3);

        // 6: asynchronous reset during LONG, released with the button still held
        hold(1, 13);
        check("t6_long_before", long_press, 1);
        #2 reset = 1'b0;
        #1 check("t6_async_clear", pack(press_pulse, release_pulse, long_press, repeat_pulse, press_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_press_after_reset", press_pulse, 1);
        check("t6_count_after_reset", press_count, 1);
        hold(0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
